inst_mem_arb: RTL
=================

# inst_mem_arb

Controller and arbiter for the single-port synchronous instruction RAM. It shares the RAM between the core fetch port (reads) and the program loader port (writes), and sequences boot: the core is held until the loader signals that the image is complete. It sits between the fetch stage, the loader (UART/debug), and the RAM macro.

## Interface

Parameters:
- `CPU_WIDTH`, 32, data and byte-address width.
- `ADDR_WIDTH`, 10, RAM word-address width (depth 2^ADDR_WIDTH).
- `STARVE_MAX`, 4, maximum consecutive load grants while a fetch is pending before the fetch is forced through (legal range 1..15).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fetch_req` in 1: fetch request; held high until granted.
- `fetch_addr` in CPU_WIDTH: fetch byte address.
- `fetch_gnt` out 1: fetch accepted this cycle.
- `fetch_rvalid` out 1: `fetch_rdata` valid; registered.
- `fetch_rdata` out CPU_WIDTH: instruction word (pass-through of `mem_rdata`).
- `load_req` in 1: write request; held until granted.
- `load_addr` in CPU_WIDTH: write byte address.
- `load_wdata` in CPU_WIDTH: write data.
- `load_gnt` out 1: write accepted this cycle.
- `load_done` in 1: one-cycle pulse; image complete.
- `core_hold` out 1: holds the core in reset/stall while in BOOT.
- `mem_en` out 1: RAM access enable.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_WIDTH: RAM word address.
- `mem_wdata` out CPU_WIDTH: RAM write data.
- `mem_rdata` in CPU_WIDTH: RAM read data, one cycle after the read enable.

## Operation

- **FSM states**:
  - BOOT (reset state). Fetch is never granted, `core_hold`=1, and loads are granted whenever requested.
  - BOOT→RUN on the cycle `load_done`=1. RUN is effective from the next cycle.
  - RUN. Arbitrated access, `core_hold`=0. RUN is left only by reset; `load_done` in RUN is ignored.
- **Arbitration in RUN**: at most one grant per cycle. Loads win by default. Fetch wins when `load_req`=0, or when `starve_cnt`==STARVE_MAX.
- **Starvation counter (`starve_cnt`)**:
  - Width: 4 bits.
  - Increments in a RUN cycle where `fetch_req`=1 and the load was granted.
  - Clears when fetch is granted, when `fetch_req`=0, or on reset.
  - Saturates at STARVE_MAX.
- **Address mapping**: `mem_addr` = granted address bits [ADDR_WIDTH+1:2]. Bits [1:0] and the upper bits are ignored, so addresses wrap modulo 4·2^ADDR_WIDTH.
- **Memory signals**, combinational from the grant:
  - `mem_en` = `fetch_gnt` | `load_gnt`.
  - `mem_we` = `load_gnt`.
  - `mem_wdata` = `load_wdata`.
  - `mem_addr` = 0 when idle.
- **Read data return**: `fetch_rvalid` is registered `fetch_gnt`, so it is high exactly one cycle after each fetch grant. `fetch_rdata` = `mem_rdata`, meaningful only when `fetch_rvalid`=1.
- **Write→read ordering**: a load granted in cycle N followed by a fetch of the same word in cycle N+1 returns the new data in N+2.
- **Reset, including mid-operation**:
  - While `rst_n`=0, all grants, `mem_en`, and `mem_we` are forced to 0.
  - State goes to BOOT, `starve_cnt`=0, `fetch_rvalid`=0.
  - A read in flight at reset is dropped; no `rvalid` is produced.

## Timing

- Grant latency: same cycle as the request when it wins (combinational).
- Fetch latency: grant in cycle N, `fetch_rvalid`/data in N+1.
- Sustained throughput: one fetch per cycle when there is no load traffic.
- Worst-case fetch wait under continuous loads: STARVE_MAX cycles, granted in cycle STARVE_MAX+1.
- `load_done` in cycle N: fetch may first be granted, and `core_hold` first reads 0, in N+1. A load requested in the same cycle N is still granted in N.
- Reset values: `core_hold`=1, `fetch_rvalid`=0, `fetch_gnt`=0, `load_gnt`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0.

## Test plan

1. **Boot load.** Reset, then write 0x00000013 to byte addr 0x0 and 0x00100093 to 0x4 with `fetch_req` held high. Required: `fetch_gnt`=0 and `core_hold`=1 throughout, and two `load_gnt` pulses with `mem_we`=1 and `mem_addr`=0 then 1.
2. **Release.** Pulse `load_done`. In the next cycle `core_hold`=0 and fetch of 0x4 is granted. `fetch_rvalid`=1 with `fetch_rdata`=0x00100093 one cycle later.
3. **Back-to-back fetches.** Fetch 0x0, 0x4, 0x8 in consecutive cycles. Required: three consecutive grants, then `rvalid` on the three following cycles carrying the words in order.
4. **Starvation.** With STARVE_MAX=4 in RUN, hold `load_req` and `fetch_req` continuously. Required: loads granted in cycles 1–4, fetch in cycle 5, loads again from cycle 6.
5. **Wrap and alignment.** With ADDR_WIDTH=10, fetch byte addr 0x1002 → `mem_addr`=0x000. A load to 0xFFC followed by a fetch of 0x1FFC returns the written data.
6. **Reset mid-read.** Assert `rst_n`=0 in the cycle after a fetch grant. Required: no `fetch_rvalid`, BOOT state, and `core_hold`=1 immediately (asynchronous).

Source files
------------

// File: rtl/inst_mem_arb_if.sv
// -----------------------------------------------------------------------------
// inst_mem_arb_if
// Bundles the three buses around the instruction-RAM arbiter: the core fetch
// port, the program loader port and the single-port RAM macro port.
//
//   master : environment view (fetch stage, loader, RAM macro)
//   slave  : arbiter view
//
// Signals
//   fetch_req / fetch_addr      -> fetch request and byte address
//   fetch_gnt                   <- fetch accepted this cycle
//   fetch_rvalid / fetch_rdata  <- read return, one cycle after the grant
//   load_req / load_addr / load_wdata -> loader write request
//   load_gnt                    <- write accepted this cycle
//   load_done                   -> one-cycle pulse, boot image complete
//   core_hold                   <- core held while booting
//   mem_en / mem_we / mem_addr / mem_wdata <- RAM macro controls
//   mem_rdata                   -> RAM read data, one cycle after the enable
// -----------------------------------------------------------------------------
interface inst_mem_arb_if #(
  parameter int CPU_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  fetch_req;
  logic [CPU_WIDTH-1:0]  fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_rvalid;
  logic [CPU_WIDTH-1:0]  fetch_rdata;

  logic                  load_req;
  logic [CPU_WIDTH-1:0]  load_addr;
  logic [CPU_WIDTH-1:0]  load_wdata;
  logic                  load_gnt;
  logic                  load_done;

  logic                  core_hold;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [CPU_WIDTH-1:0]  mem_wdata;
  logic [CPU_WIDTH-1:0]  mem_rdata;

  modport master (
    output fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_done,
           mem_rdata,
    input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, core_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_done,
           mem_rdata,
    output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, core_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_mem_arb.sv
// -----------------------------------------------------------------------------
// inst_mem_arb
// Controller/arbiter for the single-port synchronous instruction RAM.
// Sequences boot (core held, loader owns the RAM) and, once the loader
// signals load_done, arbitrates between core fetches and loader writes.
// Loads win by default; a fetch that has watched STARVE_MAX consecutive
// load grants is forced through.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : inst_mem_arb_if.slave (fetch, load, boot and RAM signals)
// -----------------------------------------------------------------------------
module inst_mem_arb #(
  parameter int CPU_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  inst_mem_arb_if.slave      bus
);

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       fetch_rvalid_q;

  logic                  fetch_gnt;
  logic                  load_gnt;
  logic [ADDR_WIDTH-1:0] fetch_word;
  logic [ADDR_WIDTH-1:0] load_word;

  // Only the word-address field of each byte address reaches the RAM; the
  // byte offset and bits above the RAM depth wrap away.
  assign fetch_word = bus.fetch_addr[ADDR_WIDTH+1:2];
  assign load_word  = bus.load_addr[ADDR_WIDTH+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.fetch_addr[1:0], bus.fetch_addr[CPU_WIDTH-1:ADDR_WIDTH+2],
                              bus.load_addr[1:0],  bus.load_addr[CPU_WIDTH-1:ADDR_WIDTH+2]};

  // ---------------------------------------------------------------------------
  // Next-state, grant and starvation logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    starve_d  = starve_q;
    fetch_gnt = 1'b0;
    load_gnt  = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        // Loader owns the RAM; a load requested alongside load_done is
        // still granted in that same cycle.
        load_gnt = bus.load_req;
        starve_d = '0;
        if (bus.load_done) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (bus.fetch_req && (!bus.load_req || starve_q == STARVE_LIM)) begin
          fetch_gnt = 1'b1;
        end else begin
          load_gnt = bus.load_req;
        end

        if (!bus.fetch_req || fetch_gnt) begin
          starve_d = '0;
        end else if (load_gnt && starve_q != STARVE_LIM) begin
          starve_d = starve_q + 4'd1;
        end
      end

      default: state_d = ST_BOOT;
    endcase

    // Grants are combinational, so they must be killed directly while reset
    // is held rather than waiting for a clock edge.
    if (!rst_n) begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      starve_q       <= '0;
      fetch_rvalid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      starve_q       <= starve_d;
      fetch_rvalid_q <= fetch_gnt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.fetch_gnt    = fetch_gnt;
  assign bus.load_gnt     = load_gnt;
  assign bus.fetch_rvalid = fetch_rvalid_q;
  assign bus.fetch_rdata  = bus.mem_rdata;
  assign bus.core_hold    = (state_q == ST_BOOT);

  assign bus.mem_en    = fetch_gnt | load_gnt;
  assign bus.mem_we    = load_gnt;
  assign bus.mem_wdata = bus.load_wdata;
  assign bus.mem_addr  = fetch_gnt ? fetch_word :
                         load_gnt  ? load_word  : '0;

endmodule
